// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready on both sides.
// Optional rotate datapath is compiled in when SHIFTER_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module pipe_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic [TAG_W-1:0]   o_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFTER_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  typedef struct packed {
    logic               valid;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  logic   adv;
  stage_t st0;
  stage_t last;
  logic   unused_last_bits;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Entry register holds the raw request; the sign for SRA is captured here.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st0 <= '0;
    end else if (adv) begin
      st0.valid <= i_valid;
      st0.op    <= i_op;
      st0.data  <= i_data;
      st0.shamt <= i_shamt;
      st0.fill  <= (i_op == OP_SRA) && i_data[WIDTH-1];
      st0.tag   <= i_tag;
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int B   = SHAMT_W - 1 - k;
    localparam int AMT = 1 << B;

    stage_t         prev;
    stage_t         next_st;
    stage_t         q;
    logic [AMT-1:0] hi;

    if (k == 0) begin : g_head
      assign prev = st0;
    end else begin : g_tail
      assign prev = g_stage[k-1].q;
    end

    always_comb begin
      hi = {AMT{prev.fill}};
`ifdef SHIFTER_ROTATE_EN
      if (prev.op == OP_ROR) hi = prev.data[AMT-1:0];
`endif
      next_st          = prev;
      next_st.shamt[B] = 1'b0;
      if (prev.shamt[B]) begin
        if (prev.op == OP_SLL) next_st.data = {prev.data[WIDTH-1-AMT:0], {AMT{1'b0}}};
        else                   next_st.data = {hi, prev.data[WIDTH-1:AMT]};
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n)  q <= '0;
      else if (adv)  q <= next_st;
    end
  end

  assign last     = g_stage[SHAMT_W-1].q;
  assign o_valid  = last.valid;
  assign o_result = last.data;
  assign o_tag    = last.tag;

  // Control fields are fully consumed by the time a result reaches the output.
  assign unused_last_bits = ^{last.op, last.shamt, last.fill};

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter: expected results queued at drive time, checked on output.
// Rotate expectations follow SHIFTER_ROTATE_EN.
module tb_pipe_shifter;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 5;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_valid;
  logic               o_ready;
  logic [1:0]         i_op;
  logic [WIDTH-1:0]   i_data;
  logic [SHAMT_W-1:0] i_shamt;
  logic [TAG_W-1:0]   i_tag;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_result;
  logic [TAG_W-1:0]   o_tag;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] exp_res[$];
  logic [TAG_W-1:0] exp_tag[$];

  pipe_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_data(i_data), .i_shamt(i_shamt), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                             input logic [SHAMT_W-1:0] s);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
      default: begin
`ifdef SHIFTER_ROTATE_EN
        r = (s == 0) ? d : ((d >> s) | (d << (WIDTH - int'(s))));
`else
        r = d >> s;
`endif
      end
    endcase
    return r;
  endfunction

  // Sends one request into an empty pipe and waits for its result; lat counts edges after acceptance.
  task automatic xfer(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                      input logic [TAG_W-1:0] tg, input logic [WIDTH-1:0] expv,
                      output logic [WIDTH-1:0] res, output logic [TAG_W-1:0] otag, output int lat);
    exp_res.push_back(expv);
    exp_tag.push_back(tg);
    i_ready = 1'b1; i_valid = 1'b1; i_op = op; i_data = d; i_shamt = s; i_tag = tg;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    res  = o_result;
    otag = o_tag;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_op = '0;
    i_data = '0; i_shamt = '0; i_tag = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    tests_run++; if (o_result !== '0) begin tests_failed++; $display("FAIL reset_o_result got %h want 0", o_result); end
    tests_run++; if (o_tag !== '0) begin tests_failed++; $display("FAIL reset_o_tag got %h want 0", o_tag); end
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_o_ready got %b want 1", o_ready); end
  endtask

  task automatic test_srl();
    logic [WIDTH-1:0] res, e; logic [TAG_W-1:0] tg, et; int lat;
    xfer(2'b01, 32'h8000_0000, 5'd31, 5'd19, 32'h0000_0001, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e) begin tests_failed++; $display("FAIL srl_result got %h want %h", res, e); end
    tests_run++; if (tg !== et) begin tests_failed++; $display("FAIL srl_tag got %h want %h", tg, et); end
    tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL srl_latency got %0d want 5", lat); end
  endtask

  task automatic test_sra();
    logic [WIDTH-1:0] res, e; logic [TAG_W-1:0] tg, et; int lat;
    xfer(2'b10, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL sra_neg got %h/%h want %h/%h", res, tg, e, et); end
    xfer(2'b10, 32'h7FFF_FFFF, 5'd31, 5'd2, 32'h0000_0000, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL sra_pos got %h/%h want %h/%h", res, tg, e, et); end
    xfer(2'b10, 32'hC000_0001, 5'd31, 5'd3, 32'hFFFF_FFFF, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL sra_max got %h/%h want %h/%h", res, tg, e, et); end
  endtask

  task automatic test_sll();
    logic [WIDTH-1:0] res, e; logic [TAG_W-1:0] tg, et; int lat;
    xfer(2'b00, 32'h0000_0001, 5'd31, 5'd4, 32'h8000_0000, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL sll_31 got %h/%h want %h/%h", res, tg, e, et); end
    xfer(2'b00, 32'hDEAD_BEEF, 5'd0, 5'd5, 32'hDEAD_BEEF, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL sll_0 got %h/%h want %h/%h", res, tg, e, et); end
  endtask

  task automatic test_ror();
    logic [WIDTH-1:0] res, e, want; logic [TAG_W-1:0] tg, et; int lat;
`ifdef SHIFTER_ROTATE_EN
    want = 32'h1000_000F;
`else
    want = 32'h0000_000F;
`endif
    xfer(2'b11, 32'h0000_00F1, 5'd4, 5'd6, want, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL ror_4 got %h/%h want %h/%h", res, tg, e, et); end
    xfer(2'b11, 32'hA5A5_0F0F, 5'd0, 5'd7, 32'hA5A5_0F0F, res, tg, lat);
    e = exp_res.pop_front(); et = exp_tag.pop_front();
    tests_run++; if (res !== e || tg !== et) begin tests_failed++; $display("FAIL ror_0 got %h/%h want %h/%h", res, tg, e, et); end
  endtask

  task automatic test_random_ops();
    logic [WIDTH-1:0] res, e, d; logic [TAG_W-1:0] tg, et; logic [1:0] op; logic [SHAMT_W-1:0] s;
    int lat;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      d  = $urandom();
      s  = 5'($urandom_range(0, WIDTH - 1));
      xfer(op, d, s, 5'(n), model(op, d, s), res, tg, lat);
      e = exp_res.pop_front(); et = exp_tag.pop_front();
      tests_run++;
      if (res !== e || tg !== et) begin
        tests_failed++;
        $display("FAIL rand_op%0d op=%0d d=%h s=%0d got %h/%h want %h/%h", n, op, d, s, res, tg, e, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    logic [WIDTH-1:0] held;
    logic held_ok = 1'b0;
    @(negedge i_clk);
    fork
      begin
        logic acc;
        int guard;
        for (int i = 0; i < 8; i++) begin
          i_valid = 1'b1; i_op = 2'(i % 4); i_data = 32'h9234_5678 + 32'(i * 32'h0101_0101);
          i_shamt = 5'(i * 3 + 1); i_tag = 5'(i);
          guard = 0;
          do begin
            #1 acc = o_ready;
            if (acc) begin
              exp_res.push_back(model(i_op, i_data, i_shamt));
              exp_tag.push_back(i_tag);
            end
            @(negedge i_clk);
            guard++;
          end while (!acc && guard < 40);
        end
        i_valid = 1'b0;
      end
      begin
        logic [WIDTH-1:0] e; logic [TAG_W-1:0] et;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
          i_ready = !(cyc >= 6 && cyc <= 9);
          #1;
          if (o_valid && i_ready) begin
            held_ok = 1'b0;
            tests_run++;
            if (exp_res.size() == 0) begin
              tests_failed++; $display("FAIL b2b_extra got tag %h want none", o_tag);
            end else begin
              e = exp_res.pop_front(); et = exp_tag.pop_front();
              if (o_result !== e || o_tag !== et) begin
                tests_failed++; $display("FAIL b2b_result got %h/%h want %h/%h", o_result, o_tag, e, et);
              end
            end
            got++;
          end else if (o_valid) begin
            tests_run++;
            if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_stall_ready got %b want 0", o_ready); end
            if (held_ok) begin
              tests_run++;
              if (o_result !== held) begin tests_failed++; $display("FAIL b2b_stall_hold got %h want %h", o_result, held); end
            end
            held = o_result; held_ok = 1'b1;
          end
          @(negedge i_clk);
        end
      end
    join
    i_ready = 1'b1;
    tests_run++; if (got !== 8) begin tests_failed++; $display("FAIL b2b_count got %0d want 8", got); end
    tests_run++; if (exp_res.size() !== 0) begin tests_failed++; $display("FAIL b2b_leftover got %0d want 0", exp_res.size()); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_op = 2'b00; i_data = 32'hFFFF_FFF0 + 32'(i); i_shamt = '0; i_tag = 5'(20 + i);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_o_valid got %b want 0", o_valid); end
    tests_run++; if (o_result !== '0) begin tests_failed++; $display("FAIL rstmid_o_result got %h want 0", o_result); end
    for (int c = 0; c < 15; c++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rstmid_ghost got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sra();
    test_sll();
    test_ror();
    test_random_ops();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
